// File: rtl/job_sched.sv
// Run-time sequencer for the HDC encode datapath: derives per-core loop bounds from the
// job configuration by restoring division, then drives the gen and run phases.
module job_sched #(
    parameter int NUM_CORE = 32,
    parameter int ADDR_W   = 20,
    parameter int NGRAM_W  = 5,
    parameter int ITEM_W   = 16
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESETN,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_W-1:0]           cfg_addr_num,
    input  logic [NGRAM_W-1:0]          cfg_ngram,
    input  logic [ITEM_W-1:0]           cfg_item_num,
    input  logic                        stream_last_hs,
    output logic                        gen,
    output logic                        run,
    output logic [ADDR_W-1:0]           addr_i,
    output logic [ADDR_W-1:0]           addr_j,
    output logic [$clog2(NUM_CORE)-1:0] remainder,
    output logic [ITEM_W-1:0]           item_memory_num,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int CW    = $clog2(NUM_CORE);
    localparam int DCNTW = $clog2(ADDR_W + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DIV  = 3'd1;
    localparam logic [2:0] S_GEN  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state;
    logic [ADDR_W-1:0]  dividend;
    logic [NGRAM_W-1:0] part_rem;
    logic [NGRAM_W-1:0] ngram_q;
    logic [ITEM_W-1:0]  item_q;
    logic [DCNTW-1:0]   div_cnt;
    logic [ITEM_W-1:0]  gen_cnt;

    logic [NGRAM_W:0]   partial;
    logic               q_bit;
    logic [NGRAM_W-1:0] rem_next;
    logic [ADDR_W-1:0]  grams_next;
    logic [ADDR_W-1:0]  grams_hi;
    logic [CW-1:0]      grams_lo;
    logic               cfg_invalid;
    logic               div_last;

    // Dividend register shifts the quotient in from the right as the dividend bits leave on the left.
    always_comb begin
        partial    = {part_rem, dividend[ADDR_W-1]};
        q_bit      = (partial >= {1'b0, ngram_q});
        rem_next   = q_bit ? NGRAM_W'(partial - {1'b0, ngram_q}) : partial[NGRAM_W-1:0];
        grams_next = {dividend[ADDR_W-2:0], q_bit};
        grams_hi   = grams_next >> CW;
        grams_lo   = grams_next[CW-1:0];
    end

    assign cfg_invalid = (cfg_ngram == '0) || (cfg_item_num == '0) ||
                         (cfg_addr_num < ADDR_W'(cfg_ngram));
    assign div_last    = (div_cnt == DCNTW'(ADDR_W - 1));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state           <= S_IDLE;
            dividend        <= '0;
            part_rem        <= '0;
            ngram_q         <= '0;
            item_q          <= '0;
            div_cnt         <= '0;
            gen_cnt         <= '0;
            gen             <= 1'b0;
            run             <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            addr_i          <= '0;
            addr_j          <= '0;
            remainder       <= '0;
            item_memory_num <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
            gen   <= 1'b0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (cfg_invalid) begin
                            err <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            dividend <= cfg_addr_num;
                            ngram_q  <= cfg_ngram;
                            item_q   <= cfg_item_num;
                            part_rem <= '0;
                            div_cnt  <= '0;
                            state    <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    dividend <= grams_next;
                    part_rem <= rem_next;
                    div_cnt  <= div_cnt + 1'b1;
                    if (div_last) begin
                        // An exact multiple of NUM_CORE fills the last round, so no partial round remains.
                        if (grams_lo == '0) begin
                            addr_i    <= grams_hi - ADDR_W'(1);
                            remainder <= '0;
                        end else begin
                            addr_i    <= grams_hi;
                            remainder <= CW'(NUM_CORE - int'(grams_lo));
                        end
                        addr_j          <= ADDR_W'(ngram_q) - ADDR_W'(1);
                        item_memory_num <= item_q;
                        gen             <= 1'b1;
                        gen_cnt         <= '0;
                        state           <= S_GEN;
                    end
                end
                S_GEN: begin
                    gen_cnt <= gen_cnt + 1'b1;
                    if (gen_cnt == item_memory_num) begin
                        gen   <= 1'b0;
                        run   <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stream_last_hs) begin
                        run   <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_sched.sv
// Self-checking bench for job_sched: directed scenarios plus randomized jobs checked
// against an arithmetic reference model of the loop-bound derivation and phase timing.
module tb_job_sched;

    localparam int NUM_CORE = 32;
    localparam int ADDR_W   = 20;
    localparam int NGRAM_W  = 5;
    localparam int ITEM_W   = 16;
    localparam int CW       = 5;

    logic                AXIS_ACLK = 1'b0;
    logic                AXIS_ARESETN = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ADDR_W-1:0]   cfg_addr_num = '0;
    logic [NGRAM_W-1:0]  cfg_ngram = '0;
    logic [ITEM_W-1:0]   cfg_item_num = '0;
    logic                stream_last_hs = 1'b0;
    logic                gen, run, busy, done, err;
    logic [ADDR_W-1:0]   addr_i, addr_j;
    logic [CW-1:0]       remainder;
    logic [ITEM_W-1:0]   item_memory_num;

    job_sched #(
        .NUM_CORE(NUM_CORE),
        .ADDR_W  (ADDR_W),
        .NGRAM_W (NGRAM_W),
        .ITEM_W  (ITEM_W)
    ) dut (
        .AXIS_ACLK      (AXIS_ACLK),
        .AXIS_ARESETN   (AXIS_ARESETN),
        .start          (start),
        .abort          (abort),
        .cfg_addr_num   (cfg_addr_num),
        .cfg_ngram      (cfg_ngram),
        .cfg_item_num   (cfg_item_num),
        .stream_last_hs (stream_last_hs),
        .gen            (gen),
        .run            (run),
        .addr_i         (addr_i),
        .addr_j         (addr_j),
        .remainder      (remainder),
        .item_memory_num(item_memory_num),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    int checks = 0;
    int failures = 0;

    longint m_addr_i = 0, m_addr_j = 0, m_rem = 0, m_item = 0, m_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_addr_i"}, addr_i, m_addr_i);
        check({tag, "_addr_j"}, addr_j, m_addr_j);
        check({tag, "_rem"}, remainder, m_rem);
        check({tag, "_item"}, item_memory_num, m_item);
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic scramble_cfg();
        cfg_addr_num = ADDR_W'($urandom);
        cfg_ngram    = NGRAM_W'($urandom);
        cfg_item_num = ITEM_W'($urandom);
    endtask

    // One job from start pulse to completion, optional abort at a given gen cycle.
    task automatic job(input int a, input int n, input int it, input int abort_at,
                       input bit noise, input bit restart);
        int  cyc;
        int  g;
        int  d;
        bit  seen;
        longint grams;
        @(negedge AXIS_ACLK);
        cfg_addr_num = ADDR_W'(a);
        cfg_ngram    = NGRAM_W'(n);
        cfg_item_num = ITEM_W'(it);
        start = 1'b1;
        @(negedge AXIS_ACLK);
        start = 1'b0;
        scramble_cfg();
        if (n == 0 || it == 0 || a < n) begin
            m_err = 1;
            check("cfg_err_busy", busy, 0);
            seen = 0;
            repeat (ADDR_W + 4) begin
                @(negedge AXIS_ACLK);
                if (gen || run || busy) seen = 1;
            end
            check("cfg_err_quiet", seen, 0);
            check_outs("cfg_err");
            return;
        end
        m_err = 0;
        check("div_busy", busy, 1);
        check("err_clear", err, 0);
        cyc = 1;
        while (!gen && cyc < ADDR_W + 6) begin
            @(negedge AXIS_ACLK);
            cyc++;
        end
        check("start_to_gen", cyc, ADDR_W + 1);
        grams = longint'(a) / n;
        if (grams % NUM_CORE == 0) begin
            m_addr_i = grams / NUM_CORE - 1;
            m_rem    = 0;
        end else begin
            m_addr_i = grams / NUM_CORE;
            m_rem    = NUM_CORE - grams % NUM_CORE;
        end
        m_addr_j = n - 1;
        m_item   = it;
        check_outs("div");
        check("gen_run_low", run, 0);
        g = 0;
        while (gen && g <= it + 5) begin
            stream_last_hs = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (g == abort_at) abort = 1'b1;
            @(negedge AXIS_ACLK);
            g++;
            abort = 1'b0;
            stream_last_hs = 1'b0;
            if (g - 1 == abort_at) begin
                check("abort_gen", gen, 0);
                check("abort_run", run, 0);
                check("abort_busy", busy, 0);
                seen = 0;
                repeat (it + 10) begin
                    @(negedge AXIS_ACLK);
                    if (gen || run || done || busy) seen = 1;
                end
                check("abort_quiet", seen, 0);
                check_outs("abort");
                return;
            end
        end
        check("gen_len", g, it + 1);
        check("run_rise", run, 1);
        d = restart ? $urandom_range(1, 5) : $urandom_range(0, 5);
        for (int k = 0; k < d; k++) begin
            if (restart && k == 0) begin
                scramble_cfg();
                cfg_ngram = NGRAM_W'($urandom_range(1, 31));
                cfg_item_num = ITEM_W'($urandom_range(1, 100));
                start = 1'b1;
            end
            @(negedge AXIS_ACLK);
            start = 1'b0;
            check("run_hold", run, 1);
            check_outs("run");
        end
        stream_last_hs = 1'b1;
        @(negedge AXIS_ACLK);
        stream_last_hs = 1'b0;
        check("done_pulse", done, 1);
        check("done_run", run, 0);
        check("done_busy", busy, 1);
        @(negedge AXIS_ACLK);
        check("done_fall", done, 0);
        check("idle_busy", busy, 0);
        check_outs("idle");
    endtask

    initial begin
        int a, n, it, ab;
        bit seen;
        int cyc;
        repeat (2) @(negedge AXIS_ACLK);
        check("rst_gen", gen, 0);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_outs("rst");
        AXIS_ARESETN = 1'b1;

        job(900, 3, 1000, -1, 0, 0);
        job(1024, 1, 4, -1, 0, 0);
        job(100, 0, 5, -1, 0, 0);
        job(2, 3, 5, -1, 0, 0);
        job(5, 1, 0, -1, 0, 0);
        job(64, 4, 2, -1, 0, 0);
        job(900, 3, 20, 10, 0, 0);
        job(5000, 7, 8, -1, 1, 1);

        // abort together with start in IDLE drops the start
        @(negedge AXIS_ACLK);
        cfg_addr_num = ADDR_W'(10); cfg_ngram = '0; cfg_item_num = ITEM_W'(3);
        start = 1'b1; abort = 1'b1;
        @(negedge AXIS_ACLK);
        start = 1'b0; abort = 1'b0;
        check("abort_start_err", err, m_err);
        check("abort_start_busy", busy, 0);
        cfg_ngram = NGRAM_W'(2);
        start = 1'b1; abort = 1'b1;
        @(negedge AXIS_ACLK);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy2", busy, 0);
        check_outs("abort_start");

        // abort during division leaves previous results in place
        @(negedge AXIS_ACLK);
        cfg_addr_num = ADDR_W'(777); cfg_ngram = NGRAM_W'(5); cfg_item_num = ITEM_W'(9);
        start = 1'b1;
        @(negedge AXIS_ACLK);
        start = 1'b0;
        m_err = 0;
        repeat (4) @(negedge AXIS_ACLK);
        abort = 1'b1;
        @(negedge AXIS_ACLK);
        abort = 1'b0;
        check("div_abort_busy", busy, 0);
        seen = 0;
        repeat (ADDR_W + 5) begin
            @(negedge AXIS_ACLK);
            if (gen || run || done) seen = 1;
        end
        check("div_abort_quiet", seen, 0);
        check_outs("div_abort");

        for (int j = 0; j < 16; j++) begin
            n  = $urandom_range(0, 31);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, (1 << ADDR_W) - 1);
            it = $urandom_range(0, 30);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, it) : -1;
            job(a, n, it, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of RUN
        @(negedge AXIS_ACLK);
        cfg_addr_num = ADDR_W'(64); cfg_ngram = NGRAM_W'(2); cfg_item_num = ITEM_W'(3);
        start = 1'b1;
        @(negedge AXIS_ACLK);
        start = 1'b0;
        cyc = 0;
        while (!run && cyc < 100) begin
            @(negedge AXIS_ACLK);
            cyc++;
        end
        check("areset_reach_run", run, 1);
        #2 AXIS_ARESETN = 1'b0;
        #1;
        m_addr_i = 0; m_addr_j = 0; m_rem = 0; m_item = 0; m_err = 0;
        check("areset_run", run, 0);
        check("areset_busy", busy, 0);
        check("areset_gen", gen, 0);
        check_outs("areset");
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;
        job(3000, 6, 5, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
